scan_chain_ctrl: RTL
====================

Name: scan_chain_ctrl

Overview:
Scan-chain controller that drives a chain of scannable 1-bit configuration registers from the writer side. It accepts configuration words over a valid/ready interface and serialises them LSB-first onto the chain's scan_in with scan_en and wen asserted. It simultaneously captures the bits shifting out of the chain's scan_out and returns them as readback words. It sits between the configuration loader and the fabric's configuration scan chain.

Parameters:
CHAIN_LEN, 64, number of scannable bits in the chain; must be a nonzero multiple of WORD_WIDTH
WORD_WIDTH, 8, bits per input/readback word; must be at least 2

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  asynchronous active-high reset
start  input  1  begin one full-chain pass; sampled only in IDLE
in_data  input  WORD_WIDTH  configuration word to shift in
in_valid  input  1  in_data valid
in_ready  output  1  controller can accept a word this cycle
chain_scan_in  output  1  serial data to first chain element
chain_scan_en  output  1  scan enable to all chain elements
chain_wen  output  1  write enable to all chain elements
chain_scan_out  input  1  serial data from last chain element
out_data  output  WORD_WIDTH  readback word
out_valid  output  1  one-cycle pulse, out_data valid
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of pass

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-high reset, rst. All registers update on posedge clk.
- Reset, asynchronous, takes effect immediately, including mid-pass: state goes to IDLE; shift register, readback register, bit counter and total counter clear to 0. Outputs after reset: in_ready=0, chain_scan_in=0, chain_scan_en=0, chain_wen=0, out_data=0, out_valid=0, busy=0, done=0. Chain contents are not restored; a partial pass is simply abandoned.
- States:
  - IDLE: if start=1, go to WAIT_WORD and clear the total-bit counter; otherwise stay.
  - WAIT_WORD: in_ready=1. On in_valid&in_ready, load in_data into the shift register, set bit counter to WORD_WIDTH and go to SHIFT.
  - SHIFT: chain_scan_en=1, chain_wen=1 and chain_scan_in=shreg[0], decoded from the state register with no extra latency. At each edge:
    - shreg shifts right by 1.
    - chain_scan_out, sampled pre-edge, enters the readback register MSB side, shifting it right, so the first bit out lands in bit 0 after WORD_WIDTH shifts.
    - Bit counter decrements; total counter increments.
    - On the edge where the bit counter goes 1->0: register out_valid=1 and out_data=completed readback word for the next cycle. Go to DONE if total reaches CHAIN_LEN, else WAIT_WORD.
  - DONE: done=1 for exactly one cycle, then IDLE.
- in_ready=0 outside WAIT_WORD; words offered then are not consumed.
- Exactly one chain shift per SHIFT cycle. chain_scan_en and chain_wen are 0 in all other states, so the chain holds its value.
- Per word: 1 accept cycle + WORD_WIDTH shift cycles. Minimum pass length is CHAIN_LEN/WORD_WIDTH*(WORD_WIDTH+1) cycles plus one DONE cycle.
- out_valid coincides with the first WAIT_WORD or DONE cycle after a word. A word can be accepted in that same cycle. There is no backpressure on out_valid.
- start while busy is ignored. start in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- in_valid deasserted indefinitely in WAIT_WORD: the controller waits and the chain holds.
- Ordering: after a full pass, bit 0 of the first word sits in the last chain element (nearest chain_scan_out). Readback words return the previous chain contents in that same ordering.
- Counter widths: bit counter uses clog2(WORD_WIDTH+1) bits; total counter uses clog2(CHAIN_LEN+1) bits. Neither wraps within a pass.

Test Plan:
- Reset state, CHAIN_LEN=16, WORD_WIDTH=8, chain modelled as 16 scannable 1-bit registers: assert rst -> all outputs 0. Pulse start -> in_ready=1 next cycle, busy=1.
- Full load: send 0xA5 then 0x3C back-to-back with in_valid held -> in_ready low for 8 cycles per word. chain_scan_in follows 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0. done pulses once after the 16th shift. Chain element 15 holds bit 0 of 0xA5.
- Readback: from the chain state above, run a second pass loading 0x00,0x00 -> out_data pulses 0xA5 then 0x3C, each with a 1-cycle out_valid.
- Stall: hold in_valid=0 for 5 cycles between words -> chain_scan_en=0 and chain_wen=0 throughout the gap; chain unchanged; pass completes correctly.
- Ignored start: pulse start during SHIFT and during DONE -> no effect. Pulse in the following IDLE cycle -> new pass begins.
- Mid-pass reset: assert rst during the 3rd shift of the second word -> immediate IDLE, all outputs 0. A subsequent full pass loads correctly.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// Writer-side scan-chain controller: serialises configuration words LSB-first into
// a chain of 1-bit registers while capturing the displaced bits as readback words.
module scan_chain_ctrl #(
    parameter int unsigned CHAIN_LEN  = 64,
    parameter int unsigned WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  chain_scan_in,
    output logic                  chain_scan_en,
    output logic                  chain_wen,
    input  logic                  chain_scan_out,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BCW = $clog2(WORD_WIDTH + 1);
    localparam int unsigned TCW = $clog2(CHAIN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WORD_WIDTH-1:0] shreg;
    logic [WORD_WIDTH-2:0] rdreg;
    logic [WORD_WIDTH-1:0] rd_nx;
    logic [BCW-1:0]        bit_cnt;
    logic [TCW-1:0]        total_cnt;
    logic                  start_pass;
    logic                  accept;
    logic                  last_bit;

    // Readback word as it stands after absorbing the bit currently on chain_scan_out
    assign rd_nx = {chain_scan_out, rdreg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        start_pass = 1'b0;
        accept     = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_pass = 1'b1;
                    state_nx   = WAIT_WORD;
                end
            end
            WAIT_WORD: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == BCW'(1)) begin
                    last_bit = 1'b1;
                    state_nx = (total_cnt == TCW'(CHAIN_LEN - 1)) ? DONE : WAIT_WORD;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Chain strobes are plain state decodes so each SHIFT cycle is exactly one chain shift
    assign in_ready      = (state == WAIT_WORD);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign chain_scan_en = (state == SHIFT);
    assign chain_wen     = (state == SHIFT);
    assign chain_scan_in = (state == SHIFT) & shreg[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            rdreg     <= '0;
            bit_cnt   <= '0;
            total_cnt <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= last_bit;
            if (start_pass) begin
                total_cnt <= '0;
            end
            if (accept) begin
                shreg   <= in_data;
                bit_cnt <= BCW'(WORD_WIDTH);
            end
            if (state == SHIFT) begin
                shreg     <= shreg >> 1;
                rdreg     <= rd_nx[WORD_WIDTH-1:1];
                bit_cnt   <= bit_cnt - BCW'(1);
                total_cnt <= total_cnt + TCW'(1);
            end
            if (last_bit) begin
                out_data <= rd_nx;
            end
        end
    end

endmodule
